// File: rtl/fetch_ctrl_unit.sv
// fetch_ctrl_unit
// Fetch-stage sequencer: drives PC write, IF/ID write, bubble injection and
// interrupt injection. Handles IMM_OPCODE instructions followed by IMM_WORDS
// extension words. Interrupts are edge-latched, served lowest index first,
// and not nested: after one is taken, no other is taken until RTI is decoded.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   opcode, ra      fields of the word currently in IF/ID
//   stall_in        hazard stall request
//   flush_in        taken-branch flush request
//   irq             level interrupt lines, edge-detected internally
//   PC_Write_En     PC register update enable
//   IF_ID_Write_En  IF/ID register write enable
//   Inject_Bubble   replace decoded control with NOP
//   Inject_Int      select interrupt vector at the PC mux
//   Int_Vec         index of the serviced interrupt line
//   Int_Active      high during the S_INTR push cycle
module fetch_ctrl_unit #(
    parameter int unsigned OPCODE_W   = 4,
    parameter int unsigned IMM_OPCODE = 12,
    parameter int unsigned IMM_WORDS  = 1,
    parameter int unsigned RTI_OPCODE = 11,
    parameter int unsigned RTI_RA     = 3,
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned VEC_W      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          ra,
    input  logic                stall_in,
    input  logic                flush_in,
    input  logic [NUM_IRQ-1:0]  irq,
    output logic                PC_Write_En,
    output logic                IF_ID_Write_En,
    output logic                Inject_Bubble,
    output logic                Inject_Int,
    output logic [VEC_W-1:0]    Int_Vec,
    output logic                Int_Active
);

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        FETCH     = 2'd1,
        FETCH_IMM = 2'd2,
        S_INTR    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NUM_IRQ-1:0]   r_irq_q;
    logic [NUM_IRQ-1:0]   r_pending;
    logic                 r_int_en;
    logic [2:0]           r_imm_cnt;
    logic [VEC_W-1:0]     r_vec_q;

    logic [VEC_W-1:0]     w_pick;
    logic                 w_found;
    logic [NUM_IRQ-1:0]   w_clr;
    logic                 w_take_int;
    logic                 w_start_imm;
    logic                 w_dec_imm;
    logic                 w_rti;

    // Lowest-index pending line.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!w_found && r_pending[i]) begin
                w_pick  = VEC_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_clr = w_take_int ? (NUM_IRQ'(1) << w_pick) : '0;

    always_comb begin
        w_next         = r_state;
        PC_Write_En    = 1'b1;
        IF_ID_Write_En = 1'b1;
        Inject_Bubble  = 1'b0;
        Inject_Int     = 1'b0;
        Int_Active     = 1'b0;
        Int_Vec        = r_vec_q;
        w_take_int     = 1'b0;
        w_start_imm    = 1'b0;
        w_dec_imm      = 1'b0;
        w_rti          = 1'b0;
        if (rst) begin
            PC_Write_En    = 1'b0;
            IF_ID_Write_En = 1'b0;
            Inject_Bubble  = 1'b1;
            Int_Vec        = '0;
            w_next         = RESET;
        end else begin
            case (r_state)
                RESET: begin
                    Inject_Bubble = 1'b1;
                    w_next        = FETCH;
                end
                FETCH: begin
                    if (flush_in) begin
                        Inject_Bubble = 1'b1;
                    end else if (stall_in) begin
                        PC_Write_En    = 1'b0;
                        IF_ID_Write_En = 1'b0;
                        Inject_Bubble  = 1'b1;
                    end else if (r_int_en && w_found) begin
                        Inject_Int = 1'b1;
                        Int_Vec    = w_pick;
                        w_take_int = 1'b1;
                        w_next     = S_INTR;
                    end else if (opcode == OPCODE_W'(IMM_OPCODE)) begin
                        IF_ID_Write_En = 1'b0;
                        Inject_Bubble  = 1'b1;
                        w_start_imm    = 1'b1;
                        w_next         = FETCH_IMM;
                    end else if (opcode == OPCODE_W'(RTI_OPCODE) && ra == 2'(RTI_RA)) begin
                        w_rti = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    if (flush_in) begin
                        Inject_Bubble = 1'b1;
                        w_next        = FETCH;
                    end else if (stall_in) begin
                        PC_Write_En    = 1'b0;
                        IF_ID_Write_En = 1'b0;
                        Inject_Bubble  = 1'b1;
                    end else if (r_imm_cnt != 3'd0) begin
                        IF_ID_Write_En = 1'b0;
                        Inject_Bubble  = 1'b1;
                        w_dec_imm      = 1'b1;
                    end else begin
                        w_next = FETCH;
                    end
                end
                S_INTR: begin
                    Int_Active = 1'b1;
                    if (stall_in) begin
                        PC_Write_En    = 1'b0;
                        IF_ID_Write_En = 1'b0;
                    end else begin
                        w_next = FETCH;
                    end
                end
                default: w_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RESET;
            r_irq_q   <= '0;
            r_pending <= '0;
            r_int_en  <= 1'b1;
            r_imm_cnt <= '0;
            r_vec_q   <= '0;
        end else begin
            r_state   <= w_next;
            r_irq_q   <= irq;
            // A new rising edge wins over a service-clear of the same line.
            r_pending <= (r_pending & ~w_clr) | (irq & ~r_irq_q);
            if (w_take_int) begin
                r_vec_q  <= w_pick;
                r_int_en <= 1'b0;
            end else if (w_rti) begin
                r_int_en <= 1'b1;
            end
            if (w_start_imm) begin
                r_imm_cnt <= 3'(IMM_WORDS - 1);
            end else if (w_dec_imm) begin
                r_imm_cnt <= r_imm_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Testbench for fetch_ctrl_unit (IMM_WORDS=3, other parameters default).
// Each cycle's stimulus and its expected output word are listed per scenario;
// expectations are queued when stimulus is driven and compared at the falling
// edge. Output word: {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int,
// Int_Active, Int_Vec[1:0]}.
module tb_fetch_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = '0;
    logic [1:0] ra = '0;
    logic       stall_in = 1'b0;
    logic       flush_in = 1'b0;
    logic [3:0] irq = '0;
    logic       PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, Int_Active;
    logic [1:0] Int_Vec;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] op;
        logic [1:0] ra;
        logic       st;
        logic       fl;
        logic [3:0] irq;
        logic [6:0] exp;
    } vec_t;

    logic [6:0] exp_q[$];

    fetch_ctrl_unit #(.IMM_WORDS(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .ra(ra),
        .stall_in(stall_in), .flush_in(flush_in), .irq(irq),
        .PC_Write_En(PC_Write_En), .IF_ID_Write_En(IF_ID_Write_En),
        .Inject_Bubble(Inject_Bubble), .Inject_Int(Inject_Int),
        .Int_Vec(Int_Vec), .Int_Active(Int_Active)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] o(input logic pc, input logic ifid, input logic bub,
                                     input logic inj, input logic act, input logic [1:0] vec);
        return {pc, ifid, bub, inj, act, vec};
    endfunction

    function automatic vec_t s(input logic r, input logic [3:0] op, input logic [1:0] a,
                               input logic st, input logic fl, input logic [3:0] iq,
                               input logic [6:0] e);
        return '{rst: r, op: op, ra: a, st: st, fl: fl, irq: iq, exp: e};
    endfunction

    task automatic test_reset();
        vec_t t[$];
        logic [6:0] obs, e;
        t.push_back(s(1, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0)));
        t.push_back(s(1, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0)));
        t.push_back(s(1, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 1, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 0)));
        foreach (t[i]) begin
            rst = t[i].rst; opcode = t[i].op; ra = t[i].ra;
            stall_in = t[i].st; flush_in = t[i].fl; irq = t[i].irq;
            exp_q.push_back(t[i].exp);
            @(negedge clk);
            obs = {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, Int_Active, Int_Vec};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset cyc%0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm();
        vec_t t[$];
        logic [6:0] obs, e;
        t.push_back(s(0, 12, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 0)));
        foreach (t[i]) begin
            rst = t[i].rst; opcode = t[i].op; ra = t[i].ra;
            stall_in = t[i].st; flush_in = t[i].fl; irq = t[i].irq;
            exp_q.push_back(t[i].exp);
            @(negedge clk);
            obs = {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, Int_Active, Int_Vec};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL imm cyc%0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm_stall();
        vec_t t[$];
        logic [6:0] obs, e;
        t.push_back(s(0, 12, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 0, 1, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 0, o(1, 1, 0, 0, 0, 0)));
        foreach (t[i]) begin
            rst = t[i].rst; opcode = t[i].op; ra = t[i].ra;
            stall_in = t[i].st; flush_in = t[i].fl; irq = t[i].irq;
            exp_q.push_back(t[i].exp);
            @(negedge clk);
            obs = {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, Int_Active, Int_Vec};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL imm_stall cyc%0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Lines 1 and 3 rise together; line 1 is served, line 3 waits for RTI.
    // An RTI under stall or with the wrong ra must not re-enable interrupts.
    task automatic test_irq_rti();
        vec_t t[$];
        logic [6:0] obs, e;
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 0, 0, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 1, 0, 1)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 0, 1, 1)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 0, 0, 1)));
        t.push_back(s(0, 11, 3, 1, 0, 4'b1010, o(0, 0, 1, 0, 0, 1)));
        t.push_back(s(0, 11, 2, 0, 0, 4'b1010, o(1, 1, 0, 0, 0, 1)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 0, 0, 1)));
        t.push_back(s(0, 11, 3, 0, 0, 4'b1010, o(1, 1, 0, 0, 0, 1)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 1, 0, 3)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 0, 1, 3)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1010, o(1, 1, 0, 0, 0, 3)));
        foreach (t[i]) begin
            rst = t[i].rst; opcode = t[i].op; ra = t[i].ra;
            stall_in = t[i].st; flush_in = t[i].fl; irq = t[i].irq;
            exp_q.push_back(t[i].exp);
            @(negedge clk);
            obs = {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, Int_Active, Int_Vec};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL irq_rti cyc%0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Flush beats both a pending interrupt and an IMM opcode; interrupt is
    // taken next cycle. In S_INTR, stall holds and flush is ignored.
    task automatic test_flush_intr();
        vec_t t[$];
        logic [6:0] obs, e;
        t.push_back(s(0, 11, 3, 0, 0, 4'b1011, o(1, 1, 0, 0, 0, 3)));
        t.push_back(s(0, 12, 0, 0, 1, 4'b1011, o(1, 1, 1, 0, 0, 3)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1011, o(1, 1, 0, 1, 0, 0)));
        t.push_back(s(0, 0, 0, 1, 0, 4'b1011, o(0, 0, 0, 0, 1, 0)));
        t.push_back(s(0, 0, 0, 0, 1, 4'b1011, o(1, 1, 0, 0, 1, 0)));
        t.push_back(s(0, 0, 0, 0, 0, 4'b1011, o(1, 1, 0, 0, 0, 0)));
        foreach (t[i]) begin
            rst = t[i].rst; opcode = t[i].op; ra = t[i].ra;
            stall_in = t[i].st; flush_in = t[i].fl; irq = t[i].irq;
            exp_q.push_back(t[i].exp);
            @(negedge clk);
            obs = {PC_Write_En, IF_ID_Write_En, Inject_Bubble, Inject_Int, Int_Active, Int_Vec};
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL flush_intr cyc%0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_imm_stall();
        test_irq_rti();
        test_flush_intr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
